// File: rtl/color_selector_pkg.sv
// Shared constants for the colour-selector step sequencer: step numbers,
// push-button codes, saturation limits and the colour-to-RGB lookup.
package color_selector_pkg;

    localparam logic [6:0] LW_STEP_DEF   = 7'h11;
    localparam logic [6:0] SEG_STEP_DEF  = 7'h49;
    localparam logic [6:0] LED_STEP_DEF  = 7'h4A;
    localparam logic [6:0] LAST_STEP_DEF = 7'h4B;

    localparam logic [1:0] COLOR_MAX = 2'd2;
    localparam logic [4:0] LEVEL_MAX = 5'd31;

    // Only these exact one-hot codes move the level; multi-hot is ignored.
    localparam logic [2:0] PB_INC     = 3'b100;
    localparam logic [2:0] PB_DEC     = 3'b001;
    localparam int         PB_COL_BIT = 1;

    localparam logic [23:0] RGB_RED   = 24'hFF0000;
    localparam logic [23:0] RGB_GREEN = 24'h00FF00;
    localparam logic [23:0] RGB_BLUE  = 24'h0000FF;

    typedef enum logic [1:0] {
        COL_RED   = 2'd0,
        COL_GREEN = 2'd1,
        COL_BLUE  = 2'd2
    } color_e;

    function automatic logic [23:0] color_rgb(input logic [1:0] c);
        case (c)
            COL_RED:   return RGB_RED;
            COL_GREEN: return RGB_GREEN;
            COL_BLUE:  return RGB_BLUE;
            default:   return 24'h000000;
        endcase
    endfunction

endpackage

// File: rtl/color_selector_wrapper_cs_step_seq.sv
// Free-running 7-bit step counter that wraps after LAST_STEP, plus registered
// one-cycle strobes that are high while the counter equals each event step.
module cs_step_seq
    import color_selector_pkg::*;
#(
    parameter logic [6:0] LW_STEP   = LW_STEP_DEF,
    parameter logic [6:0] SEG_STEP  = SEG_STEP_DEF,
    parameter logic [6:0] LED_STEP  = LED_STEP_DEF,
    parameter logic [6:0] LAST_STEP = LAST_STEP_DEF
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic [6:0] pc,
    output logic       lw_hit,
    output logic       seg_hit,
    output logic       led_hit
);

    logic [6:0] pc_next;

    always_comb begin
        pc_next = (pc == LAST_STEP) ? 7'h00 : pc + 7'h01;
    end

    // Strobes are decoded from pc_next so they line up with pc without a
    // combinational compare on the output side.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pc      <= 7'h00;
            lw_hit  <= (LW_STEP  == 7'h00);
            seg_hit <= (SEG_STEP == 7'h00);
            led_hit <= (LED_STEP == 7'h00);
        end else begin
            pc      <= pc_next;
            lw_hit  <= (pc_next == LW_STEP);
            seg_hit <= (pc_next == SEG_STEP);
            led_hit <= (pc_next == LED_STEP);
        end
    end

endmodule

// File: rtl/color_selector_wrapper.sv
// Colour-selector application wrapper: hardwired step sequencer driving LEDs,
// seven-segment level, OLED pixel and UART. Optional macro: UART_ECHO_EN.
module color_selector_wrapper
    import color_selector_pkg::*;
#(
    parameter int         N_LEDs_OUT = 8,
    parameter int         N_DIPs     = 16,
    parameter int         N_PBs      = 3,
    parameter logic [6:0] LW_STEP    = LW_STEP_DEF,
    parameter logic [6:0] SEG_STEP   = SEG_STEP_DEF,
    parameter logic [6:0] LED_STEP   = LED_STEP_DEF,
    parameter logic [6:0] LAST_STEP  = LAST_STEP_DEF
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [N_DIPs-1:0]     DIP,
    input  logic [N_PBs-1:0]      PB,
    output logic [N_LEDs_OUT-1:0] LED_OUT,
    output logic [6:0]            LED_PC,
    output logic [31:0]           SEVENSEGHEX,
    output logic [7:0]            UART_TX,
    input  logic                  UART_TX_ready,
    output logic                  UART_TX_valid,
    input  logic [7:0]            UART_RX,
    input  logic                  UART_RX_valid,
    output logic                  UART_RX_ack,
    output logic                  OLED_Write,
    output logic [6:0]            OLED_Col,
    output logic [5:0]            OLED_Row,
    output logic [23:0]           OLED_Data,
    input  logic [31:0]           ACCEL_Data,
    output logic                  ACCEL_DReady
);

    logic              lw_hit, seg_hit, led_hit;
    logic [N_PBs-1:0]  pb_q;
    logic [N_DIPs-1:0] dip_q;
    logic [31:0]       accel_q;
    logic [4:0]        level_q;
    logic [1:0]        color_q;
    logic [1:0]        color_nxt;
    logic              oled_write_q;
    logic [6:0]        oled_col_q;
    logic [23:0]       oled_data_q;
    logic              rx_hold_q, rx_ack_q, rx_accept;
    logic signed [1:0] level_delta;

    function automatic logic [4:0] sat_level(input logic [4:0] lvl,
                                             input logic signed [1:0] delta);
        logic signed [6:0] sum;
        sum = $signed({2'b00, lvl}) + 7'(delta);
        if (sum < 7'sd0)
            return 5'd0;
        else if (sum > $signed({2'b00, LEVEL_MAX}))
            return LEVEL_MAX;
        else
            return sum[4:0];
    endfunction

    function automatic logic [1:0] color_step(input logic [1:0] c, input logic adv);
        case (c)
            COL_RED:   return adv ? COL_GREEN : COL_RED;
            COL_GREEN: return adv ? COL_BLUE  : COL_GREEN;
            COL_BLUE:  return adv ? COL_RED   : COL_BLUE;
            default:   return COL_RED;
        endcase
    endfunction

    cs_step_seq #(
        .LW_STEP   (LW_STEP),
        .SEG_STEP  (SEG_STEP),
        .LED_STEP  (LED_STEP),
        .LAST_STEP (LAST_STEP)
    ) u_seq (
        .CLK     (CLK),
        .RESET   (RESET),
        .pc      (LED_PC),
        .lw_hit  (lw_hit),
        .seg_hit (seg_hit),
        .led_hit (led_hit)
    );

    always_comb begin
        level_delta = 2'sd0;
        if (pb_q == N_PBs'(PB_INC))
            level_delta = 2'sd1;
        else if (pb_q == N_PBs'(PB_DEC))
            level_delta = -2'sd1;
        color_nxt = color_step(color_q, pb_q[PB_COL_BIT]);
    end

    // Input sampling, level/colour update and OLED pixel write.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pb_q         <= '0;
            dip_q        <= '0;
            accel_q      <= '0;
            level_q      <= '0;
            color_q      <= COL_RED;
            oled_write_q <= 1'b0;
            oled_col_q   <= '0;
            oled_data_q  <= '0;
        end else begin
            if (lw_hit) begin
                pb_q    <= PB;
                dip_q   <= DIP;
                accel_q <= ACCEL_Data;
            end
            if (seg_hit)
                level_q <= sat_level(level_q, level_delta);
            if (led_hit) begin
                color_q     <= color_nxt;
                oled_col_q  <= {2'b00, level_q};
                oled_data_q <= color_rgb(color_nxt);
            end
            oled_write_q <= led_hit;
        end
    end

`ifdef UART_ECHO_EN
    logic [7:0] tx_data_q;
    logic       tx_valid_q;

    // A new byte is held off while the previous echo is still pending.
    assign rx_accept = UART_RX_valid && !rx_hold_q && !tx_valid_q;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else if (rx_accept) begin
            tx_data_q  <= UART_RX;
            tx_valid_q <= 1'b1;
        end else if (tx_valid_q && UART_TX_ready) begin
            tx_valid_q <= 1'b0;
        end
    end

    assign UART_TX       = tx_data_q;
    assign UART_TX_valid = tx_valid_q;
`else
    assign rx_accept     = UART_RX_valid && !rx_hold_q;
    assign UART_TX       = 8'h00;
    assign UART_TX_valid = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rx_hold_q <= 1'b0;
            rx_ack_q  <= 1'b0;
        end else begin
            rx_ack_q <= rx_accept;
            if (!UART_RX_valid)
                rx_hold_q <= 1'b0;
            else if (rx_accept)
                rx_hold_q <= 1'b1;
        end
    end

    assign UART_RX_ack  = rx_ack_q;
    assign ACCEL_DReady = lw_hit;
    assign LED_OUT      = N_LEDs_OUT'(color_q);
    assign SEVENSEGHEX  = {16'h0000, level_q, 11'h000};
    assign OLED_Write   = oled_write_q;
    assign OLED_Col     = oled_col_q;
    assign OLED_Row     = 6'd0;
    assign OLED_Data    = oled_data_q;

endmodule

// File: tb/tb_color_selector_wrapper.sv
// Scoreboard bench for color_selector_wrapper: expected level/colour pushed when
// the buttons are driven, popped and compared at the step where they appear.
module tb_color_selector_wrapper;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] DIP;
    logic [2:0]  PB;
    logic [7:0]  LED_OUT;
    logic [6:0]  LED_PC;
    logic [31:0] SEVENSEGHEX;
    logic [7:0]  UART_TX;
    logic        UART_TX_ready;
    logic        UART_TX_valid;
    logic [7:0]  UART_RX;
    logic        UART_RX_valid;
    logic        UART_RX_ack;
    logic        OLED_Write;
    logic [6:0]  OLED_Col;
    logic [5:0]  OLED_Row;
    logic [23:0] OLED_Data;
    logic [31:0] ACCEL_Data;
    logic        ACCEL_DReady;

    typedef struct packed {
        logic [1:0] color;
        logic [4:0] level;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_level = 0;
    int   m_color = 0;

    color_selector_wrapper dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .DIP           (DIP),
        .PB            (PB),
        .LED_OUT       (LED_OUT),
        .LED_PC        (LED_PC),
        .SEVENSEGHEX   (SEVENSEGHEX),
        .UART_TX       (UART_TX),
        .UART_TX_ready (UART_TX_ready),
        .UART_TX_valid (UART_TX_valid),
        .UART_RX       (UART_RX),
        .UART_RX_valid (UART_RX_valid),
        .UART_RX_ack   (UART_RX_ack),
        .OLED_Write    (OLED_Write),
        .OLED_Col      (OLED_Col),
        .OLED_Row      (OLED_Row),
        .OLED_Data     (OLED_Data),
        .ACCEL_Data    (ACCEL_Data),
        .ACCEL_DReady  (ACCEL_DReady)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_pc(input logic [6:0] target);
        for (int i = 0; i < 200; i++) begin
            if (LED_PC == target) return;
            tick();
        end
        chk("pc_wait", 32'(LED_PC), 32'(target));
    endtask

    function automatic logic [23:0] exp_rgb(input int c);
        case (c)
            0:       return 24'hFF0000;
            1:       return 24'h00FF00;
            default: return 24'h0000FF;
        endcase
    endfunction

    // One full sequencer loop with buttons pb; checks level at 0x4A, colour/OLED at 0x4B.
    task automatic run_loop(input logic [2:0] pb, input string tag);
        exp_t e;
        wait_pc(7'h10);
        PB         = pb;
        DIP        = 16'($urandom);
        ACCEL_Data = $urandom;
        if (pb == 3'b100 && m_level < 31) m_level = m_level + 1;
        else if (pb == 3'b001 && m_level > 0) m_level = m_level - 1;
        if (pb[1]) m_color = (m_color == 2) ? 0 : m_color + 1;
        e.color = 2'(m_color);
        e.level = 5'(m_level);
        sb.push_back(e);
        wait_pc(7'h4A);
        e = sb.pop_front();
        chk({tag, "_seg"}, SEVENSEGHEX, {16'h0, e.level, 11'h0});
        tick();
        chk({tag, "_led"}, 32'(LED_OUT), 32'(e.color));
        chk({tag, "_owr"}, 32'(OLED_Write), 32'd1);
        chk({tag, "_odat"}, 32'(OLED_Data), 32'(exp_rgb(int'(e.color))));
        chk({tag, "_ocol"}, 32'(OLED_Col), 32'(e.level));
    endtask

    initial begin
        int acks;
        RESET = 1'b0; PB = 3'b000; DIP = '0; ACCEL_Data = '0;
        UART_RX = '0; UART_RX_valid = 1'b0; UART_TX_ready = 1'b0;
        tick();
        chk("rst_pc", 32'(LED_PC), 32'd0);
        chk("rst_led", 32'(LED_OUT), 32'd0);
        chk("rst_seg", SEVENSEGHEX, 32'd0);
        chk("rst_owr", 32'(OLED_Write), 32'd0);
        chk("rst_accel", 32'(ACCEL_DReady), 32'd0);
        chk("rst_ack", 32'(UART_RX_ack), 32'd0);
        chk("rst_txv", 32'(UART_TX_valid), 32'd0);
        RESET = 1'b1;
        tick();
        chk("pc_first", 32'(LED_PC), 32'd1);

        wait_pc(7'h10);
        tick();
        chk("accel_pulse", 32'(ACCEL_DReady), 32'd1);
        tick();
        chk("accel_drop", 32'(ACCEL_DReady), 32'd0);

        for (int i = 0; i < 4; i++)  run_loop(3'b010, "color");
        for (int i = 0; i < 40; i++) run_loop(3'b100, "inc");
        for (int i = 0; i < 40; i++) run_loop(3'b001, "dec");
        for (int i = 0; i < 9; i++)  run_loop(3'b100, "inc9");
        run_loop(3'b101, "multi101");
        run_loop(3'b110, "multi110");

        wait_pc(7'h20);
        RESET = 1'b0;
        tick();
        chk("mrst_pc", 32'(LED_PC), 32'd0);
        chk("mrst_led", 32'(LED_OUT), 32'd0);
        chk("mrst_seg", SEVENSEGHEX, 32'd0);
        chk("mrst_odat", 32'(OLED_Data), 32'd0);
        chk("mrst_ocol", 32'(OLED_Col), 32'd0);
        m_level = 0;
        m_color = 0;
        RESET = 1'b1;
        tick();
        chk("mrst_pc1", 32'(LED_PC), 32'd1);
        run_loop(3'b000, "after_rst");

        UART_RX = 8'h41; UART_RX_valid = 1'b1; UART_TX_ready = 1'b0;
        acks = 0;
        tick();
        chk("rx_ack", 32'(UART_RX_ack), 32'd1);
`ifdef UART_ECHO_EN
        chk("tx_data", 32'(UART_TX), 32'h41);
`else
        chk("tx_data", 32'(UART_TX), 32'h00);
`endif
        acks += int'(UART_RX_ack);
        for (int i = 0; i < 2; i++) begin
            tick();
            acks += int'(UART_RX_ack);
`ifdef UART_ECHO_EN
            chk("tx_hold", 32'(UART_TX_valid), 32'd1);
`else
            chk("tx_off", 32'(UART_TX_valid), 32'd0);
`endif
        end
        UART_TX_ready = 1'b1;
        tick();
        acks += int'(UART_RX_ack);
        chk("tx_drain", 32'(UART_TX_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            acks += int'(UART_RX_ack);
        end
        chk("ack_once", 32'(acks), 32'd1);
        UART_RX_valid = 1'b0;
        tick();
        tick();
        UART_RX = 8'h5A; UART_RX_valid = 1'b1;
        tick();
        chk("rx_ack2", 32'(UART_RX_ack), 32'd1);
`ifdef UART_ECHO_EN
        chk("tx_data2", 32'(UART_TX), 32'h5A);
`else
        chk("tx_data2", 32'(UART_TX), 32'h00);
`endif
        tick();
        chk("rx_ack2_drop", 32'(UART_RX_ack), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
